// File: rtl/gan_mac_arbiter.sv
// gan_mac_arbiter: round-robin arbiter for a shared MAC engine, with a hold-time watchdog.
//
// Grant sequence: IDLE picks a requester, GRANTED holds the grant, and COOLDOWN
// keeps the engine idle for one cycle. Because the IDLE decision is registered,
// two grants are always separated by at least two cycles with no grant.
//
// Ports
//   clk_i          clock (all logic on the rising edge)
//   rst_i          synchronous active-high reset
//   req_i          level request per requester
//   release_i      one-cycle pulse from the holder to end its use
//   err_clr_i      clears timeout_err_o
//   grant_o        one-hot ownership of the engine (registered)
//   grant_id_o     index of the current holder (valid while busy_o)
//   busy_o         OR of grant_o (registered)
//   timeout_err_o  sticky flag, set when the watchdog revokes a grant
//   err_id_o       index of the requester that was revoked last
//
// state     | meaning
// S_IDLE    | no holder; grant the first pending request at or after rr_ptr
// S_GRANTED | one requester owns the engine; the hold counter runs
// S_COOLDOWN| one forced idle cycle after a release or a revoke
module gan_mac_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2,
   parameter int TIMEOUT  = 4096
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [NUM_REQ-1:0]  release_i,
   input  logic                err_clr_i,
   output logic [NUM_REQ-1:0]  grant_o,
   output logic [ID_WIDTH-1:0] grant_id_o,
   output logic                busy_o,
   output logic                timeout_err_o,
   output logic [ID_WIDTH-1:0] err_id_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_GRANTED  = 2'd1,
      S_COOLDOWN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                busy_q, busy_d;
   logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    hold_q, hold_d;
   logic                err_q, err_d;
   logic [ID_WIDTH-1:0] err_id_q, err_id_d;

   // Round-robin pick: rotate the request vector so rr_ptr lands on bit 0,
   // then take the lowest set bit of the rotated vector.
   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] req_rot;
   logic                 pick_vld;
   logic [ID_WIDTH-1:0]  pick_id;

   assign req_dbl = {req_i, req_i};
   assign req_rot = req_dbl >> rr_ptr_q;

   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_vld && req_rot[k]) begin
            pick_vld = 1'b1;
            pick_id  = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   // grant_q is one-hot, so masking with it isolates the holder's bits and
   // makes non-holder release pulses irrelevant.
   logic hold_rel;
   logic hold_req;

   assign hold_rel = |(release_i & grant_q);
   assign hold_req = |(req_i & grant_q);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      hold_d     = hold_q;
      err_d      = err_q & ~err_clr_i;
      err_id_d   = err_id_q;

      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (pick_vld) begin
               state_d    = S_GRANTED;
               grant_d    = NUM_REQ'(1) << pick_id;
               grant_id_d = pick_id;
               rr_ptr_d   = ID_WIDTH'((int'(pick_id) + 1) % NUM_REQ);
               hold_d     = '0;
            end
         end
         S_GRANTED: begin
            if (hold_rel || !hold_req) begin
               state_d = S_COOLDOWN;
               grant_d = '0;
            end else if (hold_q == HOLD_LAST) begin
               // Watchdog revoke; its set overrides a simultaneous err_clr.
               state_d  = S_COOLDOWN;
               grant_d  = '0;
               err_d    = 1'b1;
               err_id_d = grant_id_q;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_COOLDOWN: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = |grant_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         hold_q     <= '0;
         err_q      <= 1'b0;
         err_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_q     <= hold_d;
         err_q      <= err_d;
         err_id_q   <= err_id_d;
      end
   end

   assign grant_o       = grant_q;
   assign busy_o        = busy_q;
   assign grant_id_o    = grant_id_q;
   assign timeout_err_o = err_q;
   assign err_id_o      = err_id_q;

endmodule

// File: tb/tb_gan_mac_arbiter.sv
// tb_gan_mac_arbiter: directed scenarios plus a randomized run, all compared
// against a transaction-level reference model of the arbiter.
module tb_gan_mac_arbiter;

   localparam int N   = 4;
   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] rel;
   logic         err_clr;
   logic [N-1:0] grant_o;
   logic [1:0]   grant_id_o;
   logic         busy_o;
   logic         timeout_err_o;
   logic [1:0]   err_id_o;

   int checks = 0;
   int errors = 0;

   gan_mac_arbiter #(.NUM_REQ(N), .ID_WIDTH(2), .TIMEOUT(TMO)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .release_i     (rel),
      .err_clr_i     (err_clr),
      .grant_o       (grant_o),
      .grant_id_o    (grant_id_o),
      .busy_o        (busy_o),
      .timeout_err_o (timeout_err_o),
      .err_id_o      (err_id_o)
   );

   always #5 clk = ~clk;

   // Reference model: owner index (-1 = nobody), cycles the grant has been
   // visible so far, forced-quiet flag after a grant ends, round-robin start.
   int m_owner = -1;
   int m_held  = 0;
   bit m_cool  = 1'b0;
   int m_ptr   = 0;
   int m_gid   = 0;
   bit m_err   = 1'b0;
   int m_eid   = 0;

   task automatic m_step();
      bit found;
      if (rst) begin
         m_owner = -1; m_held = 0; m_cool = 1'b0; m_ptr = 0;
         m_gid = 0; m_err = 1'b0; m_eid = 0;
         return;
      end
      if (err_clr) m_err = 1'b0;
      if (m_owner >= 0) begin
         if (rel[m_owner] || !req[m_owner]) begin
            m_owner = -1;
            m_cool  = 1'b1;
         end else begin
            m_held++;
            if (m_held == TMO) begin
               m_err   = 1'b1;
               m_eid   = m_owner;
               m_owner = -1;
               m_cool  = 1'b1;
            end
         end
      end else if (m_cool) begin
         m_cool = 1'b0;
      end else if (req != 0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!found && req[i]) begin
               found   = 1'b1;
               m_owner = i;
               m_held  = 0;
               m_gid   = i;
               m_ptr   = (i + 1) % N;
            end
         end
      end
   endtask

   function automatic logic [9:0] exp_vec();
      logic [3:0] g;
      g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      return {g, 2'(m_gid), (m_owner >= 0), m_err, 2'(m_eid)};
   endfunction

   wire [9:0] dut_vec = {grant_o, grant_id_o, busy_o, timeout_err_o, err_id_o};

   // Inputs only change 1 time unit after a rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic drain();
      req = '0; rel = '0; err_clr = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; rel = '0; err_clr = 1'b0;
      tick(); tick();
      checks++;
      if (dut_vec !== 10'b0) begin
         errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec, 10'b0);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++; $display("FAIL post_reset_idle: got %b want %b", dut_vec, exp_vec());
      end
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int n_gr = 0;
      int gap = 0;
      bit prev_busy = 1'b0;
      req = 4'b1111; rel = '0;
      for (int c = 0; c < 80 && n_gr < 5; c++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL rr_model: got %b want %b", dut_vec, exp_vec());
         end
         if (busy_o && !prev_busy) begin
            if (n_gr > 0) begin
               checks++;
               if (gap != 2) begin
                  errors++; $display("FAIL rr_gap: got %0d want 2", gap);
               end
            end
            checks++;
            if (int'(grant_id_o) != exp_order[n_gr]) begin
               errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", n_gr, grant_id_o, exp_order[n_gr]);
            end
            n_gr++;
            gap = 0;
         end
         if (!busy_o) gap++;
         prev_busy = busy_o;
         rel = (m_owner >= 0 && m_held == 2) ? 4'(1 << m_owner) : 4'b0;
      end
      checks++;
      if (n_gr < 5) begin
         errors++; $display("FAIL rr_budget: got %0d grants want 5", n_gr);
      end
      rel = '0;
   endtask

   task automatic test_single();
      drain();
      req = 4'b0100;
      tick();
      checks++;
      if (grant_o !== 4'b0100) begin
         errors++; $display("FAIL single_grant: got %b want 0100", grant_o);
      end
      checks++;
      if (grant_id_o !== 2'd2) begin
         errors++; $display("FAIL single_id: got %0d want 2", grant_id_o);
      end
      checks++;
      if (busy_o !== 1'b1) begin
         errors++; $display("FAIL single_busy: got %b want 1", busy_o);
      end
   endtask

   task automatic test_nonholder_release();
      rel = 4'b1011;
      tick();
      checks++;
      if (grant_o !== 4'b0100 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL nonholder_release: got %b want grant 0100", grant_o);
      end
      rel = '0;
      tick();
      checks++;
      if (grant_o !== 4'b0100) begin
         errors++; $display("FAIL nonholder_after: got %b want 0100", grant_o);
      end
   endtask

   task automatic test_timeout();
      int held = 0;
      drain();
      req = 4'b0010;
      tick();
      for (int c = 0; c < 40 && busy_o; c++) begin
         held++;
         tick();
      end
      checks++;
      if (held != TMO) begin
         errors++; $display("FAIL timeout_len: got %0d want %0d", held, TMO);
      end
      checks++;
      if (grant_o !== 4'b0 || timeout_err_o !== 1'b1 || err_id_o !== 2'd1) begin
         errors++; $display("FAIL timeout_flag: got grant %b err %b id %0d want 0000 1 1",
                            grant_o, timeout_err_o, err_id_o);
      end
      req = '0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (timeout_err_o !== 1'b0 || err_id_o !== 2'd1) begin
         errors++; $display("FAIL err_clr: got err %b id %0d want 0 1", timeout_err_o, err_id_o);
      end
   endtask

   task automatic test_err_clr_race();
      drain();
      req = 4'b1000;
      for (int c = 0; c < 40; c++) begin
         tick();
         err_clr = (m_owner >= 0 && m_held == TMO - 1);
      end
      err_clr = 1'b0;
      checks++;
      if (timeout_err_o !== 1'b1 || err_id_o !== 2'd3 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL set_beats_clr: got err %b id %0d want 1 3", timeout_err_o, err_id_o);
      end
      req = '0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic test_release_at_timeout();
      int held = 0;
      drain();
      req = 4'b0001;
      tick();
      for (int c = 0; c < 40 && busy_o; c++) begin
         held++;
         rel = (m_owner >= 0 && m_held == TMO - 1) ? 4'(1 << m_owner) : 4'b0;
         tick();
      end
      rel = '0;
      checks++;
      if (held != TMO || timeout_err_o !== 1'b0) begin
         errors++; $display("FAIL release_wins: got held %0d err %b want %0d 0", held, timeout_err_o, TMO);
      end
   endtask

   task automatic test_reset_mid_grant();
      drain();
      req = 4'b0100;
      tick(); tick();
      rst = 1'b1; req = 4'b1111;
      tick();
      checks++;
      if (dut_vec !== 10'b0) begin
         errors++; $display("FAIL reset_mid_grant: got %b want %b", dut_vec, 10'b0);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (grant_o !== 4'b0001 || grant_id_o !== 2'd0) begin
         errors++; $display("FAIL first_after_reset: got %b id %0d want 0001 0", grant_o, grant_id_o);
      end
   endtask

   task automatic test_drop_before_grant();
      bit seen = 1'b0;
      drain();
      req = 4'b0001;
      tick();
      req = 4'b0101;
      tick();
      req = 4'b0001; rel = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         tick();
         rel = '0;
         if (grant_o[2]) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL dropped_req_granted: got grant to 2 want none");
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         rel     = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
         err_clr = ($urandom_range(0, 19) == 0);
         rst     = ($urandom_range(0, 499) == 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL random[%0d]: got %b want %b", c, dut_vec, exp_vec());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_nonholder_release();
      test_timeout();
      test_err_clr_race();
      test_release_at_timeout();
      test_reset_mid_grant();
      test_drop_before_grant();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gan_mac_arbiter.md
GAN_MAC_ARBITER -- requirements
Module: gan_mac_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the MAC engine (2..8).
REQ-002 The block SHALL have parameter ID_WIDTH, default 2: width of grant_id and err_id, equal to clog2(NUM_REQ).
REQ-003 The block SHALL have parameter TIMEOUT, default 4096: maximum number of cycles a grant may be held.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: level request per requester.
REQ-007 The block SHALL have port release, input, NUM_REQ bits: one-cycle pulse from the holder ending its use.
REQ-008 The block SHALL have port err_clr, input, 1 bit: pulse that clears timeout_err.
REQ-009 The block SHALL have port grant, output, NUM_REQ bits: one-hot ownership of the MAC engine.
REQ-010 The block SHALL have port grant_id, output, ID_WIDTH bits: index of the current holder, valid while busy.
REQ-011 The block SHALL have port busy, output, 1 bit: high while any grant is asserted.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: sticky flag set by a watchdog revoke.
REQ-013 The block SHALL have port err_id, output, ID_WIDTH bits: index of the requester that was revoked.

Function
REQ-014 The block SHALL be a state machine with three states: IDLE, GRANTED and COOLDOWN.
REQ-015 In IDLE with req nonzero, the block SHALL select the first set req bit searching from rr_ptr upward with wrap-around, assert that grant bit and busy on the next cycle, and enter GRANTED.
REQ-016 On each grant to index i, the block SHALL set rr_ptr to (i+1) mod NUM_REQ.
REQ-017 In GRANTED, grant SHALL stay constant and exactly one bit SHALL be set, regardless of other req changes.
REQ-018 In GRANTED, release[holder]=1 or req[holder]=0 SHALL clear grant and busy on the next cycle and move the block to COOLDOWN.
REQ-019 Release bits from non-holders SHALL be ignored in every state.
REQ-020 COOLDOWN SHALL last exactly one cycle with grant=0 and then return to IDLE, giving a minimum two-cycle gap between consecutive grants.
REQ-021 The hold counter SHALL clear on entry to GRANTED and increment every GRANTED cycle.
REQ-022 When the hold counter equals TIMEOUT-1 and no release occurs in that cycle, the block SHALL revoke the grant, set timeout_err=1 and err_id=holder, and enter COOLDOWN.
REQ-023 If release and timeout occur in the same cycle, release SHALL win and timeout_err SHALL not be set.
REQ-024 err_clr SHALL clear timeout_err; if a new timeout occurs in the same cycle, the set SHALL win.
REQ-025 err_id SHALL hold its value until the next timeout.
REQ-026 grant and busy SHALL be registered outputs, and busy SHALL equal the OR of the grant bits.
REQ-027 A requester whose req drops before it is granted SHALL not receive a grant.

Reset
REQ-028 While rst=1, the block SHALL set state=IDLE, grant=0, busy=0, grant_id=0, rr_ptr=0, hold counter=0, timeout_err=0 and err_id=0.
REQ-029 Reset asserted mid-grant SHALL revoke the grant on the next edge without setting timeout_err.
REQ-030 The first grant after reset SHALL favour index 0.

Verification
REQ-031 Bench SHALL drive req=4'b1111 held with the holder releasing after 3 cycles each, and SHALL check grant order 0,1,2,3,0 with a 2-cycle gap between grants.
REQ-032 Bench SHALL drive req=4'b0100 alone, and SHALL check grant=4'b0100 one cycle later, grant_id=2 and busy=1.
REQ-033 Bench SHALL drive the holder never releasing with TIMEOUT=16, and SHALL check the grant drops after 16 GRANTED cycles with timeout_err=1 and err_id equal to the holder; it SHALL then pulse err_clr and check timeout_err=0.
REQ-034 Bench SHALL pulse release from a non-holder, and SHALL check the grant is unchanged.
REQ-035 Bench SHALL assert release on the same cycle as the timeout, and SHALL check timeout_err remains 0.
REQ-036 Bench SHALL assert rst during a grant, and SHALL check that all outputs read 0 on the next cycle and that the next grant favours index 0.
